// File: rtl/pps_pkg.sv
// -----------------------------------------------------------------------------
// pps_pkg
// Shared definitions for the 16-bit pipelined processor: default datapath
// widths, opcode constants, the fetch-stage state encoding and the IF/ID
// bundle field widths that decode relies on.
// -----------------------------------------------------------------------------
package pps_pkg;

    // Datapath widths shared by fetch and decode
    localparam int PPS_ADDR_WIDTH = 8;
    localparam int PPS_DATA_WIDTH = 16;
    localparam int PPS_OP_WIDTH   = 4;
    localparam int PPS_CNT_WIDTH  = 16;

    // IF/ID bundle field widths (instr, pc, valid)
    localparam int IFID_INSTR_WIDTH = PPS_DATA_WIDTH;
    localparam int IFID_PC_WIDTH    = PPS_ADDR_WIDTH;
    localparam int IFID_VALID_WIDTH = 1;

    // Opcode constants (top OP_WIDTH bits of the instruction word)
    localparam logic [PPS_OP_WIDTH-1:0] OP_NOP  = 4'h0;
    localparam logic [PPS_OP_WIDTH-1:0] OP_ADD  = 4'h1;
    localparam logic [PPS_OP_WIDTH-1:0] OP_SUB  = 4'h2;
    localparam logic [PPS_OP_WIDTH-1:0] OP_AND  = 4'h3;
    localparam logic [PPS_OP_WIDTH-1:0] OP_LD   = 4'h4;
    localparam logic [PPS_OP_WIDTH-1:0] OP_ST   = 4'h5;
    localparam logic [PPS_OP_WIDTH-1:0] OP_BEQ  = 4'h6;
    localparam logic [PPS_OP_WIDTH-1:0] OP_JMP  = 4'h7;
    localparam logic [PPS_OP_WIDTH-1:0] OP_HALT = 4'hF;

    // Fetch-stage state encoding
    typedef enum logic [1:0] {
        FS_IDLE   = 2'b00,
        FS_RUN    = 2'b01,
        FS_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [PPS_CNT_WIDTH-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bus bundle around the fetch stage: the instruction-memory read port and the
// IF/ID pipeline register handed to decode.
//   master : fetch side  (drives im_addr/im_rd and the IF/ID fields)
//   slave  : memory/decode side
// -----------------------------------------------------------------------------
interface fetch_stage_if
    import pps_pkg::*;
#(
    parameter int ADDR_WIDTH = PPS_ADDR_WIDTH,
    parameter int DATA_WIDTH = PPS_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] im_addr;
    logic                  im_rd;
    logic [DATA_WIDTH-1:0] im_r_data;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [ADDR_WIDTH-1:0] ifid_pc;
    logic                  ifid_valid;

    modport master (
        output im_addr,
        output im_rd,
        input  im_r_data,
        output ifid_instr,
        output ifid_pc,
        output ifid_valid
    );

    modport slave (
        input  im_addr,
        input  im_rd,
        output im_r_data,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the PC, drives the instruction-memory read
// port and fills the IF/ID register. Handles start-up from IDLE, stall hold,
// redirect (branch/jump) with a one-bubble flush, and HALT detection.
// Ports:
//   clk, rst (async, active-low)
//   start        : leave IDLE and begin fetching at START_ADDR
//   stall        : hold PC, IF/ID and counter
//   redirect     : taken branch/jump, load redirect_pc and flush IF/ID
//   redirect_pc  : redirect target
//   bus (master) : im_addr/im_rd/im_r_data and ifid_instr/ifid_pc/ifid_valid
//   halted       : HALT fetched, fetch stopped
//   fetch_cnt    : instructions accepted into IF/ID, saturating
// -----------------------------------------------------------------------------
module fetch_stage
    import pps_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PPS_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = PPS_DATA_WIDTH,
    parameter int                    OP_WIDTH   = PPS_OP_WIDTH,
    parameter logic [OP_WIDTH-1:0]   HALT_OP    = OP_HALT,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    fetch_stage_if.master            bus,
    output logic                     halted,
    output logic [PPS_CNT_WIDTH-1:0] fetch_cnt
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e               state_r,      state_nxt_s;
    logic [ADDR_WIDTH-1:0]      pc_r,         pc_nxt_s;
    logic [DATA_WIDTH-1:0]      ifid_instr_r, ifid_instr_nxt_s;
    logic [ADDR_WIDTH-1:0]      ifid_pc_r,    ifid_pc_nxt_s;
    logic                       ifid_valid_r, ifid_valid_nxt_s;
    logic [PPS_CNT_WIDTH-1:0]   fetch_cnt_r,  fetch_cnt_nxt_s;
    logic                       im_rd_r,      im_rd_nxt_s;
    logic                       halted_r,     halted_nxt_s;
    logic                       is_halt_s;
    logic [PPS_CNT_WIDTH-1:0]   cnt_inc_s;

    assign is_halt_s = (bus.im_r_data[DATA_WIDTH-1 -: OP_WIDTH] == HALT_OP);

    // Saturating increment of the accepted-instruction counter
    always_comb begin
        if (fetch_cnt_r != CNT_MAX) begin
            cnt_inc_s = fetch_cnt_r + 16'd1;
        end else begin
            cnt_inc_s = fetch_cnt_r;
        end
    end

    // Next-state and next-datapath decode; redirect beats stall beats normal
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc_nxt_s    = ifid_pc_r;
        ifid_valid_nxt_s = ifid_valid_r;
        fetch_cnt_nxt_s  = fetch_cnt_r;

        case (state_r)
            FS_IDLE: begin
                if (start) begin
                    pc_nxt_s    = START_ADDR;
                    state_nxt_s = FS_RUN;
                end else begin
                    state_nxt_s = FS_IDLE;
                end
            end
            FS_RUN: begin
                if (redirect) begin
                    // In-flight word is on the wrong path, even a HALT
                    pc_nxt_s         = redirect_pc;
                    ifid_valid_nxt_s = 1'b0;
                end else if (stall) begin
                    state_nxt_s = FS_RUN;
                end else begin
                    ifid_instr_nxt_s = bus.im_r_data;
                    ifid_pc_nxt_s    = pc_r;
                    ifid_valid_nxt_s = 1'b1;
                    fetch_cnt_nxt_s  = cnt_inc_s;
                    if (is_halt_s) begin
                        // PC parks on the HALT address
                        state_nxt_s = FS_HALTED;
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
                    end
                end
            end
            FS_HALTED: begin
                if (redirect) begin
                    pc_nxt_s         = redirect_pc;
                    ifid_valid_nxt_s = 1'b0;
                    state_nxt_s      = FS_RUN;
                end else if (stall) begin
                    state_nxt_s = FS_HALTED;
                end else begin
                    // HALT has been handed to decode; empty the slot
                    ifid_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s      = FS_IDLE;
                ifid_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered decodes of the next state for the memory strobe and halt flag
    always_comb begin
        im_rd_nxt_s  = (state_nxt_s == FS_RUN);
        halted_nxt_s = (state_nxt_s == FS_HALTED);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= FS_IDLE;
            pc_r         <= {ADDR_WIDTH{1'b0}};
            ifid_instr_r <= {DATA_WIDTH{1'b0}};
            ifid_pc_r    <= {ADDR_WIDTH{1'b0}};
            ifid_valid_r <= 1'b0;
            fetch_cnt_r  <= 16'h0000;
            im_rd_r      <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc_r    <= ifid_pc_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            fetch_cnt_r  <= fetch_cnt_nxt_s;
            im_rd_r      <= im_rd_nxt_s;
            halted_r     <= halted_nxt_s;
        end
    end

    assign bus.im_addr    = pc_r;
    assign bus.im_rd      = im_rd_r;
    assign bus.ifid_instr = ifid_instr_r;
    assign bus.ifid_pc    = ifid_pc_r;
    assign bus.ifid_valid = ifid_valid_r;
    assign halted         = halted_r;
    assign fetch_cnt      = fetch_cnt_r;

endmodule
